// File: rtl/nrow_game.sv
// N-in-a-row board game controller for two players, X and O.
// Moves are placed through a one-hot cell select and a per-player strobe.
// A scan FSM then tests one anchor cell per cycle for a winning line.
// Optional feature: define NROW_GAME_WINMASK_EN to build the winning-line mask register.
// When the macro is undefined, win_mask is tied to 0.
module nrow_game #(
    parameter int unsigned BOARD_N = 3,
    parameter int unsigned WIN_LEN = 3,
    parameter int unsigned SCORE_W = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BOARD_N*BOARD_N-1:0]   sel_pos,
    input  logic                         buttonX,
    input  logic                         buttonO,
    input  logic                         new_game,
    output logic [BOARD_N*BOARD_N-1:0]   occ_square,
    output logic [BOARD_N*BOARD_N-1:0]   occ_player,
    output logic                         turnX,
    output logic                         turnO,
    output logic [7:0]                   game_st,
    output logic [BOARD_N*BOARD_N-1:0]   win_mask,
    output logic [SCORE_W-1:0]           x_wins,
    output logic [SCORE_W-1:0]           o_wins
);
    localparam int unsigned N2 = BOARD_N * BOARD_N;
    localparam int unsigned IW = $clog2(N2);

    typedef enum logic [3:0] {
        StStart, StTurnX, StErrX, StTurnO, StErrO, StCheck, StWinX, StWinO, StCats
    } state_e;

    state_e            state_q, state_d;
    logic [N2-1:0]     sq_q, sq_d, pl_q, pl_d;
    logic              mover_q, mover_d;
    logic [IW-1:0]     scan_q, scan_d;
    logic [SCORE_W-1:0] xw_q, xw_d, ow_q, ow_d;

    logic [N2-1:0]     mover_cells, line_m, hit_mask;
    logic              hit, valid, terminal;

    // Cells of the WIN_LEN line from anchor k in direction d; 0 if it leaves the board.
    // Directions: 0 left (col+1), 1 up (row+1), 2 up-left, 3 up-right (col-1).
    function automatic logic [N2-1:0] line_mask(input int k, input int d);
        int r, c, dr, dc, er, ec;
        logic [N2-1:0] m;
        r  = k / int'(BOARD_N);
        c  = k % int'(BOARD_N);
        dr = (d == 0) ? 0 : 1;
        dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
        er = r + dr * (int'(WIN_LEN) - 1);
        ec = c + dc * (int'(WIN_LEN) - 1);
        m  = '0;
        if (er < int'(BOARD_N) && ec >= 0 && ec < int'(BOARD_N)) begin
            for (int j = 0; j < int'(WIN_LEN); j++) begin
                m = m | ({{(N2-1){1'b0}}, 1'b1} << ((r + dr * j) * int'(BOARD_N) + c + dc * j));
            end
        end
        return m;
    endfunction

    // Line test at the current anchor; direction 0 takes priority on multiple hits.
    always_comb begin
        hit         = 1'b0;
        hit_mask    = '0;
        line_m      = '0;
        mover_cells = sq_q & (mover_q ? pl_q : ~pl_q);
        for (int d = 3; d >= 0; d--) begin
            line_m = line_mask(int'(scan_q), d);
            if (line_m != '0 && (line_m & ~mover_cells) == '0) begin
                hit      = 1'b1;
                hit_mask = line_m;
            end
        end
    end

    assign valid    = (sel_pos != '0) && ((sel_pos & (sel_pos - N2'(1))) == '0) &&
                      ((sel_pos & sq_q) == '0);
    assign terminal = (state_q == StWinX) || (state_q == StWinO) || (state_q == StCats);

    // Next-state logic for the FSM, board, scan index and score counters.
    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        pl_d    = pl_q;
        mover_d = mover_q;
        scan_d  = scan_q;
        xw_d    = xw_q;
        ow_d    = ow_q;
        case (state_q)
            StStart: begin
                state_d = StTurnX;
                scan_d  = '0;
            end
            StTurnX, StErrX: begin
                if (buttonX && !buttonO && valid) begin
                    sq_d    = sq_q | sel_pos;
                    pl_d    = pl_q | sel_pos;
                    mover_d = 1'b1;
                    scan_d  = '0;
                    state_d = StCheck;
                end else if (state_q == StTurnX && (buttonX || buttonO) &&
                             ((buttonX && buttonO) || !valid)) begin
                    state_d = StErrX;
                end
            end
            StTurnO, StErrO: begin
                if (buttonO && !buttonX && valid) begin
                    sq_d    = sq_q | sel_pos;
                    pl_d    = pl_q & ~sel_pos;
                    mover_d = 1'b0;
                    scan_d  = '0;
                    state_d = StCheck;
                end else if (state_q == StTurnO && (buttonX || buttonO) &&
                             ((buttonX && buttonO) || !valid)) begin
                    state_d = StErrO;
                end
            end
            StCheck: begin
                if (hit) begin
                    scan_d = '0;
                    if (mover_q) begin
                        state_d = StWinX;
                        if (xw_q != '1) xw_d = xw_q + SCORE_W'(1);
                    end else begin
                        state_d = StWinO;
                        if (ow_q != '1) ow_d = ow_q + SCORE_W'(1);
                    end
                end else if (scan_q == IW'(N2 - 1)) begin
                    scan_d  = '0;
                    state_d = (&sq_q) ? StCats : (mover_q ? StTurnO : StTurnX);
                end else begin
                    scan_d = scan_q + IW'(1);
                end
            end
            StWinX, StWinO, StCats: begin
                if (new_game) begin
                    sq_d    = '0;
                    pl_d    = '0;
                    scan_d  = '0;
                    state_d = StStart;
                end
            end
            default: state_d = StStart;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StStart;
            sq_q    <= '0;
            pl_q    <= '0;
            mover_q <= 1'b0;
            scan_q  <= '0;
            xw_q    <= '0;
            ow_q    <= '0;
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            pl_q    <= pl_d;
            mover_q <= mover_d;
            scan_q  <= scan_d;
            xw_q    <= xw_d;
            ow_q    <= ow_d;
        end
    end

`ifdef NROW_GAME_WINMASK_EN
    logic [N2-1:0] mask_q;

    // Capture the winning line on a hit; clear it when a new game starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
        end else if (state_q == StCheck && hit) begin
            mask_q <= hit_mask;
        end else if (terminal && new_game) begin
            mask_q <= '0;
        end
    end

    assign win_mask = mask_q;
`else
    assign win_mask = '0;
`endif

    assign occ_square = sq_q;
    assign occ_player = pl_q;
    assign x_wins     = xw_q;
    assign o_wins     = ow_q;
    assign turnX      = (state_q == StTurnX) || (state_q == StErrX);
    assign turnO      = (state_q == StTurnO) || (state_q == StErrO);

    // ASCII status decode from the registered state.
    always_comb begin
        game_st = 8'h6E;
        case (state_q)
            StWinX:         game_st = 8'h58;
            StWinO:         game_st = 8'h4F;
            StCats:         game_st = 8'h43;
            StErrX, StErrO: game_st = 8'h45;
            default:        game_st = 8'h6E;
        endcase
    end

endmodule

// File: tb/tb_nrow_game.sv
// Scoreboard bench for nrow_game: a 3x3 instance and a 4x4 (3-in-a-row, 1-bit score) instance.
module tb_nrow_game;
    localparam logic [7:0] SX = 8'h58, SO = 8'h4F, SC = 8'h43, SE = 8'h45, SN = 8'h6E;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [8:0]  sel3 = '0;
    logic        bx3 = 0, bo3 = 0, ng3 = 0;
    logic [8:0]  sq3, pl3, mk3;
    logic        tx3, to3;
    logic [7:0]  st3;
    logic [3:0]  xw3, ow3;

    logic [15:0] sel4 = '0;
    logic        bx4 = 0, bo4 = 0, ng4 = 0;
    logic [15:0] sq4, pl4, mk4;
    logic        tx4, to4;
    logic [7:0]  st4;
    logic [0:0]  xw4, ow4;

    nrow_game #(.BOARD_N(3), .WIN_LEN(3), .SCORE_W(4)) dut3 (
        .clk(clk), .reset(rst), .sel_pos(sel3), .buttonX(bx3), .buttonO(bo3),
        .new_game(ng3), .occ_square(sq3), .occ_player(pl3), .turnX(tx3), .turnO(to3),
        .game_st(st3), .win_mask(mk3), .x_wins(xw3), .o_wins(ow3)
    );

    nrow_game #(.BOARD_N(4), .WIN_LEN(3), .SCORE_W(1)) dut4 (
        .clk(clk), .reset(rst), .sel_pos(sel4), .buttonX(bx4), .buttonO(bo4),
        .new_game(ng4), .occ_square(sq4), .occ_player(pl4), .turnX(tx4), .turnO(to4),
        .game_st(st4), .win_mask(mk4), .x_wins(xw4), .o_wins(ow4)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tag;
        int          which;
        string       nm;
        logic [15:0] sq, pl, mk;
        logic        tx, tob;
        logic [7:0]  st;
        logic [3:0]  xw, ow;
    } exp_t;

    exp_t q[$];

    function automatic logic [15:0] em(input logic [15:0] m);
`ifdef NROW_GAME_WINMASK_EN
        return m;
`else
        return 16'h0 & m;
`endif
    endfunction

    task automatic ex(input int w, input string nm, input logic [15:0] sq, input logic [15:0] pl,
                      input logic tx, input logic tob, input logic [7:0] st,
                      input logic [15:0] mk, input logic [3:0] xw, input logic [3:0] ow);
        exp_t e;
        e.tag = cyc; e.which = w; e.nm = nm; e.sq = sq; e.pl = pl; e.mk = mk;
        e.tx = tx; e.tob = tob; e.st = st; e.xw = xw; e.ow = ow;
        q.push_back(e);
    endtask

    // Monitor: compare every expectation due at this cycle against the DUT outputs.
    exp_t        me;
    logic [15:0] a_sq, a_pl, a_mk;
    logic        a_tx, a_to;
    logic [7:0]  a_st;
    logic [3:0]  a_xw, a_ow;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            me = q.pop_front();
            if (me.which == 0) begin
                a_sq = {7'b0, sq3}; a_pl = {7'b0, pl3}; a_mk = {7'b0, mk3};
                a_tx = tx3; a_to = to3; a_st = st3; a_xw = xw3; a_ow = ow3;
            end else begin
                a_sq = sq4; a_pl = pl4; a_mk = mk4;
                a_tx = tx4; a_to = to4; a_st = st4; a_xw = {3'b0, xw4}; a_ow = {3'b0, ow4};
            end
            checks = checks + 1;
            if (me.tag != cyc || a_sq !== me.sq || a_pl !== me.pl || a_mk !== me.mk ||
                a_tx !== me.tx || a_to !== me.tob || a_st !== me.st ||
                a_xw !== me.xw || a_ow !== me.ow) begin
                errors = errors + 1;
                $display("FAIL %s: got sq=%h pl=%h tx=%b to=%b st=%h mk=%h xw=%0d ow=%0d cyc=%0d; want sq=%h pl=%h tx=%b to=%b st=%h mk=%h xw=%0d ow=%0d cyc=%0d",
                         me.nm, a_sq, a_pl, a_tx, a_to, a_st, a_mk, a_xw, a_ow, cyc,
                         me.sq, me.pl, me.tx, me.tob, me.st, me.mk, me.xw, me.ow, me.tag);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic mv(input int w, input logic [15:0] pos, input logic bx, input logic bo);
        if (w == 0) begin
            sel3 = pos[8:0]; bx3 = bx; bo3 = bo;
        end else begin
            sel4 = pos; bx4 = bx; bo4 = bo;
        end
        tick();
        bx3 = 0; bo3 = 0; bx4 = 0; bo4 = 0;
    endtask

    task automatic ngame(input int w);
        if (w == 0) ng3 = 1; else ng4 = 1;
        tick();
        ng3 = 0; ng4 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        wait_n(2);
        ex(0, "reset3", 0, 0, 0, 0, SN, 0, 0, 0);
        ex(1, "reset4", 0, 0, 0, 0, SN, 0, 0, 0);
        rst = 0;
        tick();
        ex(0, "start_tx3", 0, 0, 1, 0, SN, 0, 0, 0);
        ex(1, "start_tx4", 0, 0, 1, 0, SN, 0, 0, 0);

        // X wins with the bottom row 0,1,2
        mv(0, 16'h001, 1, 0); ex(0, "x0", 16'h001, 16'h001, 0, 0, SN, 0, 0, 0);
        wait_n(8);            ex(0, "scan8", 16'h001, 16'h001, 0, 0, SN, 0, 0, 0);
        wait_n(1);            ex(0, "to_o", 16'h001, 16'h001, 0, 1, SN, 0, 0, 0);
        mv(0, 16'h008, 0, 1); wait_n(9); ex(0, "o3", 16'h009, 16'h001, 1, 0, SN, 0, 0, 0);
        mv(0, 16'h002, 1, 0); wait_n(9); ex(0, "x1", 16'h00B, 16'h003, 0, 1, SN, 0, 0, 0);
        mv(0, 16'h010, 0, 1); wait_n(9); ex(0, "o4", 16'h01B, 16'h003, 1, 0, SN, 0, 0, 0);
        mv(0, 16'h004, 1, 0); ex(0, "x2chk", 16'h01F, 16'h007, 0, 0, SN, 0, 0, 0);
        wait_n(1); ex(0, "winx", 16'h01F, 16'h007, 0, 0, SX, em(16'h007), 1, 0);
        wait_n(2); ex(0, "winx_hold", 16'h01F, 16'h007, 0, 0, SX, em(16'h007), 1, 0);
        ngame(0);  ex(0, "ng_start", 0, 0, 0, 0, SN, 0, 1, 0);
        tick();    ex(0, "ng_tx", 0, 0, 1, 0, SN, 0, 1, 0);

        // Error paths
        mv(0, 16'h001, 1, 1); ex(0, "both_errx", 0, 0, 1, 0, SE, 0, 1, 0);
        mv(0, 16'h010, 1, 0); ex(0, "x4_from_err", 16'h010, 16'h010, 0, 0, SN, 0, 1, 0);
        wait_n(9); ex(0, "x4_to", 16'h010, 16'h010, 0, 1, SN, 0, 1, 0);
        mv(0, 16'h003, 0, 1); ex(0, "o_not_onehot", 16'h010, 16'h010, 0, 1, SE, 0, 1, 0);
        mv(0, 16'h001, 1, 0); ex(0, "x_in_erro", 16'h010, 16'h010, 0, 1, SE, 0, 1, 0);
        mv(0, 16'h100, 0, 1); ex(0, "o8", 16'h110, 16'h010, 0, 0, SN, 0, 1, 0);
        wait_n(9); ex(0, "o8_tx", 16'h110, 16'h010, 1, 0, SN, 0, 1, 0);
        mv(0, 16'h010, 1, 0); ex(0, "x_occupied", 16'h110, 16'h010, 1, 0, SE, 0, 1, 0);

        // Draw
        mv(0, 16'h001, 1, 0);
        tick(); sel3 = 9'h080; bo3 = 1; tick(); bo3 = 0; wait_n(7);
        ex(0, "chk_press_ign", 16'h111, 16'h011, 0, 1, SN, 0, 1, 0);
        mv(0, 16'h080, 0, 1); wait_n(9); ex(0, "d_o7", 16'h191, 16'h011, 1, 0, SN, 0, 1, 0);
        mv(0, 16'h002, 1, 0); wait_n(9); ex(0, "d_x1", 16'h193, 16'h013, 0, 1, SN, 0, 1, 0);
        mv(0, 16'h004, 0, 1); wait_n(9); ex(0, "d_o2", 16'h197, 16'h013, 1, 0, SN, 0, 1, 0);
        mv(0, 16'h020, 1, 0); wait_n(9); ex(0, "d_x5", 16'h1B7, 16'h033, 0, 1, SN, 0, 1, 0);
        mv(0, 16'h008, 0, 1); wait_n(9); ex(0, "d_o3", 16'h1BF, 16'h033, 1, 0, SN, 0, 1, 0);
        mv(0, 16'h040, 1, 0); wait_n(8); ex(0, "d_scan", 16'h1FF, 16'h073, 0, 0, SN, 0, 1, 0);
        wait_n(1); ex(0, "cats", 16'h1FF, 16'h073, 0, 0, SC, 0, 1, 0);
        ngame(0); tick(); ex(0, "cats_ng_tx", 0, 0, 1, 0, SN, 0, 1, 0);

        // O wins with row 3,4,5; new_game outside terminal is ignored
        ng3 = 1; tick(); ng3 = 0; ex(0, "ng_ignored", 0, 0, 1, 0, SN, 0, 1, 0);
        mv(0, 16'h001, 1, 0); wait_n(9); ex(0, "g_x0", 16'h001, 16'h001, 0, 1, SN, 0, 1, 0);
        mv(0, 16'h008, 0, 1); wait_n(9); ex(0, "g_o3", 16'h009, 16'h001, 1, 0, SN, 0, 1, 0);
        mv(0, 16'h100, 1, 0); wait_n(9); ex(0, "g_x8", 16'h109, 16'h101, 0, 1, SN, 0, 1, 0);
        mv(0, 16'h010, 0, 1); wait_n(9); ex(0, "g_o4", 16'h119, 16'h101, 1, 0, SN, 0, 1, 0);
        mv(0, 16'h080, 1, 0); wait_n(9); ex(0, "g_x7", 16'h199, 16'h181, 0, 1, SN, 0, 1, 0);
        mv(0, 16'h020, 0, 1); wait_n(3); ex(0, "g_scan3", 16'h1B9, 16'h181, 0, 0, SN, 0, 1, 0);
        wait_n(1); ex(0, "wino", 16'h1B9, 16'h181, 0, 0, SO, em(16'h038), 1, 1);
        ngame(0);  ex(0, "ng_after_o", 0, 0, 0, 0, SN, 0, 1, 1);
        tick();    ex(0, "ng_after_o_tx", 0, 0, 1, 0, SN, 0, 1, 1);

        // Reset in the middle of a scan
        mv(0, 16'h001, 1, 0); wait_n(2);
        rst = 1; tick(); ex(0, "rst_midcheck", 0, 0, 0, 0, SN, 0, 0, 0);
        ex(1, "rst4", 0, 0, 0, 0, SN, 0, 0, 0);
        rst = 0; tick(); ex(0, "rst_tx", 0, 0, 1, 0, SN, 0, 0, 0);

        // 4x4: diagonal 5,10,15
        mv(1, 16'h0020, 1, 0); wait_n(16); ex(1, "q_x5", 16'h0020, 16'h0020, 0, 1, SN, 0, 0, 0);
        mv(1, 16'h0001, 0, 1); wait_n(16); ex(1, "q_o0", 16'h0021, 16'h0020, 1, 0, SN, 0, 0, 0);
        mv(1, 16'h0400, 1, 0); wait_n(16); ex(1, "q_x10", 16'h0421, 16'h0420, 0, 1, SN, 0, 0, 0);
        mv(1, 16'h0002, 0, 1); wait_n(16); ex(1, "q_o1", 16'h0423, 16'h0420, 1, 0, SN, 0, 0, 0);
        mv(1, 16'h8000, 1, 0); wait_n(5); ex(1, "q_scan5", 16'h8423, 16'h8420, 0, 0, SN, 0, 0, 0);
        wait_n(1); ex(1, "q_diag_win", 16'h8423, 16'h8420, 0, 0, SX, em(16'h8420), 1, 0);
        ngame(1); tick(); ex(1, "q_ng_tx", 0, 0, 1, 0, SN, 0, 1, 0);

        // 4x4: 1,2,3 inside a 4-wide row; 1-bit counter saturates
        mv(1, 16'h0002, 1, 0); wait_n(16); ex(1, "r_x1", 16'h0002, 16'h0002, 0, 1, SN, 0, 1, 0);
        mv(1, 16'h0100, 0, 1); wait_n(16); ex(1, "r_o8", 16'h0102, 16'h0002, 1, 0, SN, 0, 1, 0);
        mv(1, 16'h0004, 1, 0); wait_n(16); ex(1, "r_x2", 16'h0106, 16'h0006, 0, 1, SN, 0, 1, 0);
        mv(1, 16'h0200, 0, 1); wait_n(16); ex(1, "r_o9", 16'h0306, 16'h0006, 1, 0, SN, 0, 1, 0);
        mv(1, 16'h0008, 1, 0); wait_n(1); ex(1, "r_scan1", 16'h030E, 16'h000E, 0, 0, SN, 0, 1, 0);
        wait_n(1); ex(1, "r_row_win_sat", 16'h030E, 16'h000E, 0, 0, SX, em(16'h000E), 1, 0);

        wait_n(2);
        if (q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL pending: %0d expectations never compared, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nrow_game.md
NROW_GAME -- requirements
Module: nrow_game

Interface
REQ-001 Parameter BOARD_N, default 3: board side; legal range 3..5; board has BOARD_N*BOARD_N cells, index 0 = bottom-right, row-major upward.
REQ-002 Parameter WIN_LEN, default 3: tiles in a line needed to win; legal range 3..BOARD_N.
REQ-003 Parameter SCORE_W, default 4: width of each win counter.
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sel_pos  input  BOARD_N^2  requested cell, must be one-hot.
REQ-007 buttonX, buttonO  input  1 each  single-cycle, already-debounced move strobes.
REQ-008 new_game  input  1  single-cycle strobe that restarts play from a terminal state.
REQ-009 occ_square  output  BOARD_N^2  cell occupied.
REQ-010 occ_player  output  BOARD_N^2  occupant, 1 = X, 0 = O, meaningful only where occupied.
REQ-011 turnX, turnO  output  1 each  player to move.
REQ-012 game_st  output  8  ASCII status: 'X' 0x58, 'O' 0x4F, 'C' 0x43, 'E' 0x45, 'n' 0x6E.
REQ-013 win_mask  output  BOARD_N^2  cells of the winning line.
REQ-014 x_wins, o_wins  output  SCORE_W each  saturating win counters.

Function
REQ-015 The FSM SHALL have states START, TURN_X, ERR_X, TURN_O, ERR_O, CHECK, WIN_X, WIN_O, CATS, plus a 1-bit mover register.
REQ-016 A move SHALL be valid iff sel_pos is one-hot and the selected cell is unoccupied.
REQ-017 START SHALL go to TURN_X unconditionally after one cycle.
REQ-018 In TURN_p or ERR_p, a press by p alone with a valid move SHALL set the cell's occ_square and occ_player bits, latch mover = p, and enter CHECK on the same edge.
REQ-019 In TURN_p, any press with an invalid move, or buttonX and buttonO pressed in the same cycle, SHALL enter ERR_p without changing the board.
REQ-020 In TURN_p or ERR_p, a press by the other player alone with a valid move SHALL be ignored.
REQ-021 In ERR_p, invalid presses SHALL leave the state in ERR_p.
REQ-022 CHECK SHALL scan anchor cells 0..BOARD_N^2-1, one anchor per cycle, starting on the first cycle in CHECK.
REQ-023 Each anchor SHALL be tested in four directions (left, up, up-left, up-right), counting only lines of WIN_LEN cells that lie entirely on the board and are all occupied by mover.
REQ-024 On a hit at anchor k, the FSM SHALL enter WIN_mover on the edge ending scan cycle k, and SHALL latch that line into win_mask.
REQ-025 If the hit is at anchor k, no later anchors SHALL be scanned.
REQ-026 If no anchor hits, then after BOARD_N^2 scan cycles the FSM SHALL enter CATS if every cell is occupied, otherwise TURN of the other player.
REQ-027 Presses during CHECK SHALL be ignored.
REQ-028 Entering WIN_X or WIN_O SHALL increment x_wins or o_wins respectively, holding at 2^SCORE_W-1 (saturating).
REQ-029 WIN_X, WIN_O and CATS SHALL hold until new_game.
REQ-030 On new_game in a terminal state, the FSM SHALL clear the board and win_mask and enter START; the counters SHALL be preserved.
REQ-031 new_game in any non-terminal state SHALL be ignored.
REQ-032 turnX SHALL be 1 in TURN_X and ERR_X; turnO SHALL be 1 in TURN_O and ERR_O; otherwise both SHALL be 0.
REQ-033 game_st SHALL be 'X' in WIN_X, 'O' in WIN_O, 'C' in CATS, 'E' in ERR_X and ERR_O, and 'n' otherwise.
REQ-034 All outputs SHALL be registered or decoded only from registered state.

Reset
REQ-035 While reset is sampled high, the FSM SHALL go to START and occ_square, occ_player, win_mask, x_wins, o_wins, scan index and mover SHALL go to 0, overriding all other inputs, including mid-CHECK.
REQ-036 The first edge with reset low SHALL go from START to TURN_X.

Configuration
REQ-037 With macro NROW_GAME_WINMASK_EN defined, win_mask SHALL behave per REQ-024 and REQ-030.
REQ-038 With NROW_GAME_WINMASK_EN undefined, win_mask SHALL be constant 0 and no mask register SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-039 N=3, L=3: X plays cells 0, 1, 2 with O playing 3 and 4 in between -> WIN_X, game_st 0x58, x_wins=1, win_mask=0x007 (macro defined).
REQ-040 N=3: in TURN_O, buttonO with sel_pos=0x003 -> ERR_O, game_st 0x45, board unchanged; then buttonO with sel_pos=0x100 -> CHECK, then TURN_X.
REQ-041 N=3: X and O fill the board in a draw sequence -> CATS after 9 scan cycles, game_st 0x43, counters unchanged.
REQ-042 N=4, L=3: X completes diagonal 5, 10, 15 -> WIN_X; a 3-in-a-row inside a 4-wide row is also detected.
REQ-043 buttonX and buttonO pressed together in TURN_X -> ERR_X, no tile placed.
REQ-044 reset asserted mid-CHECK -> START next cycle with all outputs 0; new_game after WIN_O -> board cleared, o_wins retained, TURN_X two cycles later.
